// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-memory fetch responder with wait states, loader port and fetch counter
//
// Purpose: serves one instruction fetch at a time. A request is accepted in IDLE,
// the word is read after WAIT_CYCLES wait states and held on the response port
// until the core takes it. Misaligned or out-of-window fetches return err with a
// zero word. A loader port writes program words at any time.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   req_i/req_addr_i   fetch request and byte address; req_ready_o high in IDLE
//   resp_valid_o       response valid; resp_ready_i completes the handshake
//   resp_inst_o        instruction word (zero on error)
//   resp_err_o         misaligned / out-of-range flag, qualified by resp_valid_o
//   ld_we_i/ld_addr_i/ld_data_i  loader word write
//   fetch_cnt_o        completed responses, wraps modulo 2^32

module inst_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [31:0]           req_addr_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_inst_o,
  output logic                  resp_err_o,
  input  logic                  ld_we_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i,
  output logic [31:0]           fetch_cnt_o
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  // Window size in bytes, one bit wider than the address so the compare cannot overflow.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] fcnt_q, fcnt_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]           cap_addr;
  logic [31:0]           cap_off;
  logic                  cap_err;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_word;

  // With zero wait states the capture happens on the acceptance edge, so the
  // live request address is used; otherwise the latched address.
  always_comb begin
    cap_addr = (state_q == S_IDLE) ? req_addr_i : addr_q;
    cap_off  = cap_addr - BASE_ADDR;
    cap_err  = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) ||
               ({1'b0, cap_off} >= SPAN_BYTES);
    cap_idx  = cap_off[DEPTH_LOG2+1:2];
    cap_word = mem_q[cap_idx];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i && req_ready_o) begin
          addr_d = req_addr_i;
          if (WAIT_CYCLES == 0) begin
            inst_d  = cap_err ? 32'h0 : cap_word;
            err_d   = cap_err;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          inst_d  = cap_err ? 32'h0 : cap_word;
          err_d   = cap_err;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          fcnt_d  = fcnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      cnt_q   <= 4'd0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
      fcnt_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Program storage is deliberately not reset so a loaded image survives reset.
  // Non-blocking write gives read-before-write when the capture hits the same word.
  always_ff @(posedge clk) begin
    if (ld_we_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  assign req_ready_o  = rst && (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_inst_o  = inst_q;
  assign resp_err_o   = err_q;
  assign fetch_cnt_o  = fcnt_q;

endmodule
